// File: rtl/pattern_detector_fsm.sv
// ---------------------------------------------------------------------------
// pattern_detector_fsm
//
// Serial sequence detector for an N-bit PATTERN on a qualified 1-bit stream.
// The state register holds the length of the longest PATTERN prefix that is
// also a suffix of the valid bits received so far. The KMP transition table
// is built at elaboration, so the runtime logic is a table lookup plus the
// output and counter registers.
//
// Parameters
//   N        pattern length, 1..16
//   PATTERN  pattern bits; bit N-1 is received first, bit 0 last
//   OVERLAP  1: matches may share bits, 0: restart from empty after a match
//   CNT_W    match counter width, 1..32
//
// Ports
//   clock        in   rising-edge clock
//   reset_b      in   asynchronous active-low reset
//   clear        in   synchronous clear of state, Out, match_count, sat
//   in_valid     in   qualifies In
//   In           in   serial data bit
//   Out          out  one-cycle match pulse (registered)
//   state        out  matched-prefix length, 0..N-1
//   match_count  out  saturating number of matches since reset/clear
//   sat          out  high while match_count is at its maximum value
// ---------------------------------------------------------------------------
module pattern_detector_fsm #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8,
  localparam int          SW      = (N < 2) ? 1 : $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             In,
  output logic             Out,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count,
  output logic             sat
);

  // Parameter legality is checked at elaboration.
  generate
    if (N < 1 || N > 16) begin : g_bad_n
      $error("pattern_detector_fsm: N must be in 1..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("pattern_detector_fsm: CNT_W must be in 1..32");
    end
  endgenerate

  localparam int TBL = 1 << SW;

  // Bit of the pattern seen at receive position pos (0 = first received).
  function automatic int pat_bit(input int pos);
    return PATTERN[N-1-pos] ? 1 : 0;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length s) + b.
  // A result of N means the bit completes a match.
  function automatic int delta_fn(input int s, input int b);
    int best;
    int idx;
    int wbit;
    bit ok;
    best = 0;
    if (s < N) begin
      for (int k = 1; k <= N; k++) begin
        if (k <= s + 1) begin
          ok = 1'b1;
          for (int j = 0; j < k; j++) begin
            idx  = s + 1 - k + j;
            wbit = (idx == s) ? b : pat_bit(idx);
            if (pat_bit(j) != wbit) ok = 1'b0;
          end
          if (ok) best = k;
        end
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int fail_fn();
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < N; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pat_bit(j) != pat_bit(N - k + j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam logic [SW-1:0]    N_S     = SW'(N);
  localparam logic [SW-1:0]    FAIL_S  = SW'(fail_fn());
  localparam logic [SW-1:0]    RESTART = OVERLAP ? FAIL_S : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Transition table, padded to a power of two so the state register can
  // index it directly; entries at or above N are unreachable and hold 0.
  logic [SW-1:0] delta0 [TBL];
  logic [SW-1:0] delta1 [TBL];

  genvar gi;
  generate
    for (gi = 0; gi < TBL; gi++) begin : g_delta
      localparam int D0 = delta_fn(gi, 0);
      localparam int D1 = delta_fn(gi, 1);
      assign delta0[gi] = SW'(D0);
      assign delta1[gi] = SW'(D1);
    end
  endgenerate

  // Prefix length; numeric rather than enumerated because its range
  // follows N.
  typedef logic [SW-1:0] prefix_t;

  prefix_t          state_reg, state_next;
  prefix_t          ns;
  logic             out_reg, out_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             sat_reg, sat_next;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= '0;
      out_reg   <= 1'b0;
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      count_reg <= count_next;
      sat_reg   <= sat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    out_next   = 1'b0;
    count_next = count_reg;
    sat_next   = sat_reg;
    ns         = In ? delta1[state_reg] : delta0[state_reg];

    if (clear) begin
      state_next = '0;
      count_next = '0;
      sat_next   = 1'b0;
    end else if (in_valid) begin
      if (ns == N_S) begin
        // Completed match: pulse, fall back to the overlap restart point,
        // and count without wrapping.
        out_next   = 1'b1;
        state_next = RESTART;
        if (count_reg != CNT_MAX) begin
          count_next = count_reg + 1'b1;
        end
        sat_next = (count_next == CNT_MAX);
      end else begin
        state_next = ns;
      end
    end
  end

  assign Out         = out_reg;
  assign state       = state_reg;
  assign match_count = count_reg;
  assign sat         = sat_reg;

endmodule

// File: tb/tb_pattern_detector_fsm.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector_fsm
//
// Three detectors share one stimulus stream: default parameters (a),
// OVERLAP=0 (b) and CNT_W=2 (c). A reference model keeps the recent valid
// bits and compares them with the pattern directly; a negedge process
// checks every instance against it each cycle, and directed steps pin the
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_pattern_detector_fsm;

  logic clock = 1'b0;
  logic reset_b = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic In = 1'b0;

  always #5 clock = ~clock;

  logic       out_a, out_b, out_c;
  logic [2:0] state_a, state_b, state_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  pattern_detector_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clock(clock), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .In(In),
    .Out(out_a), .state(state_a), .match_count(cnt_a), .sat(sat_a));

  pattern_detector_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clock(clock), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .In(In),
    .Out(out_b), .state(state_b), .match_count(cnt_b), .sat(sat_b));

  pattern_detector_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clock(clock), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .In(In),
    .Out(out_c), .state(state_c), .match_count(cnt_c), .sat(sat_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  pat = 4'b1011;
  logic [15:0] m_hist [3] = '{16'd0, 16'd0, 16'd0};
  int m_len   [3] = '{0, 0, 0};
  int m_out   [3] = '{0, 0, 0};
  int m_state [3] = '{0, 0, 0};
  int m_cnt   [3] = '{0, 0, 0};
  int m_sat   [3] = '{0, 0, 0};
  int m_ovl   [3] = '{1, 0, 1};
  int m_max   [3] = '{255, 255, 3};

  // Longest k<4 such that the last k bits received equal the first k
  // pattern bits.
  function automatic int prefix_len(input logic [15:0] h, input int len);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < 4; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (h[j] != pat[4-k+j]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (!reset_b || clear) begin
        m_hist[i] = '0; m_len[i] = 0; m_out[i] = 0;
        m_state[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
      end else if (in_valid) begin
        m_hist[i] = {m_hist[i][14:0], In};
        if (m_len[i] < 16) m_len[i]++;
        if (m_len[i] >= 4 && m_hist[i][3:0] == pat) begin
          m_out[i] = 1;
          if (m_cnt[i] < m_max[i]) m_cnt[i]++;
          if (m_ovl[i] == 0) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
          end
        end else begin
          m_out[i] = 0;
        end
        m_state[i] = prefix_len(m_hist[i], m_len[i]);
        m_sat[i]   = (m_cnt[i] == m_max[i]) ? 1 : 0;
      end else begin
        m_out[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_b);
    model_update();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    $display("%b %b %b || %b %0d %0d", reset_b, in_valid, In, out_a, state_a, cnt_a);
    chk("a.Out",   int'(out_a),   m_out[0]);
    chk("a.state", int'(state_a), m_state[0]);
    chk("a.count", int'(cnt_a),   m_cnt[0]);
    chk("a.sat",   int'(sat_a),   m_sat[0]);
    chk("b.Out",   int'(out_b),   m_out[1]);
    chk("b.state", int'(state_b), m_state[1]);
    chk("b.count", int'(cnt_b),   m_cnt[1]);
    chk("b.sat",   int'(sat_b),   m_sat[1]);
    chk("c.Out",   int'(out_c),   m_out[2]);
    chk("c.state", int'(state_c), m_state[2]);
    chk("c.count", int'(cnt_c),   m_cnt[2]);
    chk("c.sat",   int'(sat_c),   m_sat[2]);
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic v, input logic b);
    in_valid = v;
    In       = b;
    clear    = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  logic [6:0] s1 = 7'b1011011;
  logic [7:0] s3 = 8'b10101011;
  int exp3 [8] = '{1, 2, 3, 2, 3, 2, 3, 1};
  logic [12:0] s5 = 13'b1011011011011;

  initial begin
    // reset
    repeat (2) @(posedge clock);
    #1;
    chk("rst.Out", int'(out_a), 0);
    chk("rst.state", int'(state_a), 0);
    chk("rst.count", int'(cnt_a), 0);
    reset_b = 1'b1;

    // stream 1,0,1,1,0,1,1
    for (int i = 6; i >= 0; i--) begin
      send(1'b1, s1[i]);
      if (i == 3) chk("t1.out_bit4", int'(out_a), 1);
      if (i == 2) chk("t1.out_bit5", int'(out_a), 0);
    end
    chk("t1.out_bit7", int'(out_a), 1);
    chk("t1.count", int'(cnt_a), 2);
    chk("t1.state", int'(state_a), 1);
    chk("t2.out_bit7", int'(out_b), 0);
    chk("t2.count", int'(cnt_b), 1);
    chk("t2.state", int'(state_b), 1);
    do_clear();
    chk("clr.count", int'(cnt_a), 0);

    // stream 1,0,1,0,1,0,1,1
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, s3[i]);
      chk("t3.state", int'(state_a), exp3[7-i]);
      chk("t3.out", int'(out_a), (i == 0) ? 1 : 0);
    end
    chk("t3.count", int'(cnt_a), 1);
    do_clear();

    // gap with toggling In
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("t4.gap_state", int'(state_a), 2);
      chk("t4.gap_out", int'(out_a), 0);
    end
    send(1'b1, 1'b1);
    chk("t4.out_pre", int'(out_a), 0);
    send(1'b1, 1'b1);
    chk("t4.out_final", int'(out_a), 1);
    chk("t4.count", int'(cnt_a), 1);
    do_clear();

    // four overlapping matches, 2-bit counter saturates
    for (int i = 12; i >= 0; i--) begin
      send(1'b1, s5[i]);
      if (i == 9) begin chk("t5.cnt1", int'(cnt_c), 1); chk("t5.sat1", int'(sat_c), 0); end
      if (i == 6) begin chk("t5.cnt2", int'(cnt_c), 2); chk("t5.sat2", int'(sat_c), 0); end
      if (i == 3) begin chk("t5.cnt3", int'(cnt_c), 3); chk("t5.sat3", int'(sat_c), 1); end
      if (i == 0) begin chk("t5.cnt4", int'(cnt_c), 3); chk("t5.sat4", int'(sat_c), 1); end
    end
    chk("t5.count_a", int'(cnt_a), 4);
    do_clear();
    chk("t5.clr_cnt", int'(cnt_c), 0);
    chk("t5.clr_sat", int'(sat_c), 0);

    // clear on the completing bit
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    clear = 1'b1; in_valid = 1'b1; In = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("t6.clr_out", int'(out_a), 0);
    chk("t6.clr_cnt", int'(cnt_a), 0);
    chk("t6.clr_state", int'(state_a), 0);

    // asynchronous reset mid-pattern
    send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b1); send(1'b1, 1'b1);
    send(1'b1, 1'b0); send(1'b1, 1'b1);
    chk("t6.pre_state", int'(state_a), 3);
    chk("t6.pre_cnt", int'(cnt_a), 1);
    @(negedge clock);
    #2;
    reset_b = 1'b0;
    #1;
    chk("t6.rst_state", int'(state_a), 0);
    chk("t6.rst_cnt", int'(cnt_a), 0);
    chk("t6.rst_out", int'(out_a), 0);
    @(posedge clock);
    #1;
    reset_b = 1'b1;
    send(1'b1, 1'b1);
    chk("t6.post_state", int'(state_a), 1);
    chk("t6.post_out", int'(out_a), 0);

    // pseudo-random tail, checked by the model
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) do_clear();
      else send($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
    end

    in_valid = 1'b0;
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
